// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed table: entry n is the pattern for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side signal bundle: word/page/control inputs and the scanned digit outputs.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 32,
  parameter int PAGE_W     = 2
);

  logic [DATA_W-1:0]     data_in;
  logic [PAGE_W-1:0]     page_sel;
  logic                  hold;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output data_in, page_sel, hold, blank_lz, dp_mask,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  data_in, page_sel, hold, blank_lz, dp_mask,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver with per-frame snapshot, paging and
// leading-zero blanking. Outputs are registered and only move on a digit tick.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 50000,
  parameter int PAGE_W      = 2
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NIBBLES = DATA_W / 4;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
  logic [PAGE_W-1:0]     shadow_page_q, shadow_page_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic       tick;
  logic       frame_wrap;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic       blank;

  assign tick       = (presc_q == PRESC_W'(REFRESH_DIV - 1));
  assign frame_wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    if (tick) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    shadow_data_d = shadow_data_q;
    shadow_page_d = shadow_page_q;
    if (frame_wrap && !bus.hold) begin
      shadow_data_d = bus.data_in;
      shadow_page_d = bus.page_sel;
    end
    frame_done_d  = frame_wrap;
  end

  // The slot being entered is decoded from the next idx and next shadow, so the
  // first digit after a wrap already shows the freshly captured word.
  always_comb begin
    int nib_base;
    int cur_pos;
    logic upper_zero;
    nib_base   = int'(shadow_page_d) * NUM_DIGITS;
    cur_pos    = nib_base + int'(idx_d);
    cur_nib    = 4'(shadow_data_d >> (4 * cur_pos));
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_d) && (nib_base + k) < NIBBLES &&
          4'(shadow_data_d >> (4 * (nib_base + k))) != 4'h0)
        upper_zero = 1'b0;
    end
    blank = (cur_pos >= NIBBLES) ||
            (bus.blank_lz && (idx_d != '0) && upper_zero);
  end

  seg_hex_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick) begin
      if (blank) begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(NUM_DIGITS'(1) << idx_d);
        seg_d = dec_seg;
        dp_d  = ~bus.dp_mask[idx_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_page_q <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_page_q <= shadow_page_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a short refresh divider so frames are 16 cycles.
module tb_seg_scan_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000,
                         SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001,
                         SF = 7'b0001110, SX = 7'h7F;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  int   waited;

  seg_scan_driver_if #(.NUM_DIGITS(4), .DATA_W(32), .PAGE_W(2)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS  (4),
    .DATA_W      (32),
    .REFRESH_DIV (4),
    .PAGE_W      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [1:0] page,
                               input logic hold, input logic blz, input logic [3:0] dpm);
    bus.data_in  = data;
    bus.page_sel = page;
    bus.hold     = hold;
    bus.blank_lz = blz;
    bus.dp_mask  = dpm;
  endtask

  // Advance negedges until frame_done is seen (bounded); returns cycles taken.
  task automatic waitFrame(output int cycles);
    cycles = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.frame_done) break;
    end
    checkOutput("frame_seen", 32'(bus.frame_done), 32'd1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_an"}, 32'(bus.an), 32'hF);
    checkOutput({tag, "_seg"}, 32'(bus.seg), 32'(SX));
    checkOutput({tag, "_dp"}, 32'(bus.dp), 32'd1);
    checkOutput({tag, "_fd"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic captureFrame(input string tag, input logic [3:0][3:0] expAn,
                              input logic [3:0][6:0] expSeg, input logic [3:0] expDp);
    int c;
    waitFrame(c);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("%s_an%0d", tag, d), 32'(bus.an), 32'(expAn[d]));
      checkOutput($sformatf("%s_seg%0d", tag, d), 32'(bus.seg), 32'(expSeg[d]));
      checkOutput($sformatf("%s_dp%0d", tag, d), 32'(bus.dp), 32'(expDp[d]));
      if (d < 3) repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    applyStimulus(32'h0, 2'd0, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("rst0");
    rst = 1'b0;

    applyStimulus(32'h1234ABCD, 2'd0, 1'b0, 1'b0, 4'b0101);
    captureFrame("p0", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SA, SB, SC, SD}, 4'b1010);

    applyStimulus(32'h1234ABCD, 2'd1, 1'b0, 1'b0, 4'b0000);
    captureFrame("p1", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {S1, S2, S3, S4}, 4'b1111);

    applyStimulus(32'h1234ABCD, 2'd2, 1'b0, 1'b0, 4'b1111);
    captureFrame("p2", {4'hF, 4'hF, 4'hF, 4'hF}, {SX, SX, SX, SX}, 4'b1111);

    applyStimulus(32'h00000005, 2'd0, 1'b0, 1'b1, 4'b0000);
    captureFrame("lz5", {4'hF, 4'hF, 4'hF, 4'b1110}, {SX, SX, SX, S5}, 4'b1111);

    applyStimulus(32'h00000000, 2'd0, 1'b0, 1'b1, 4'b0000);
    captureFrame("lz0", {4'hF, 4'hF, 4'hF, 4'b1110}, {SX, SX, SX, S0}, 4'b1111);

    applyStimulus(32'h00000800, 2'd0, 1'b0, 1'b1, 4'b0000);
    captureFrame("lz8", {4'hF, 4'b1011, 4'b1101, 4'b1110}, {SX, S8, S0, S0}, 4'b1111);

    // Mid-frame update must not tear the frame in progress.
    applyStimulus(32'h1234ABCD, 2'd0, 1'b0, 1'b0, 4'b0000);
    waitFrame(waited);
    checkOutput("mid_seg0", 32'(bus.seg), 32'(SD));
    @(negedge clk);
    applyStimulus(32'h55556789, 2'd0, 1'b0, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("mid_seg1", 32'(bus.seg), 32'(SC));
    repeat (4) @(negedge clk);
    checkOutput("mid_seg2", 32'(bus.seg), 32'(SB));
    repeat (4) @(negedge clk);
    checkOutput("mid_seg3", 32'(bus.seg), 32'(SA));
    waitFrame(waited);
    checkOutput("mid_new_an", 32'(bus.an), 32'b1110);
    checkOutput("mid_new_seg", 32'(bus.seg), 32'(S9));

    applyStimulus(32'hFFFFFFFF, 2'd1, 1'b1, 1'b0, 4'b0000);
    for (int f = 0; f < 3; f++) begin
      waitFrame(waited);
      checkOutput($sformatf("hold_seg_f%0d", f), 32'(bus.seg), 32'(S9));
    end
    applyStimulus(32'hFFFFFFFF, 2'd0, 1'b0, 1'b0, 4'b0000);
    waitFrame(waited);
    checkOutput("unhold_seg", 32'(bus.seg), 32'(SF));

    // Reset in the middle of a frame, then confirm the scan restarts from idx 0.
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkReset("rst_mid");
    repeat (20) @(negedge clk);
    checkReset("rst_held");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_idle_an", 32'(bus.an), 32'hF);
    @(negedge clk);
    checkOutput("post_rst_an1", 32'(bus.an), 32'b1101);
    checkOutput("post_rst_seg1", 32'(bus.seg), 32'(S0));
    checkOutput("post_rst_fd", 32'(bus.frame_done), 32'd0);
    waitFrame(waited);
    checkOutput("post_rst_wrap_cycles", 32'(waited), 32'd12);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: width of the displayed word, a multiple of 4.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot (>=2).
REQ-004 SHALL have parameter PAGE_W, default 2: width of page_sel.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: port clk, the single clock, and port rst, the asynchronous active-high reset.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 data_in  input  DATA_W  word to display, e.g. PC or a register value.
REQ-009 page_sel  input  PAGE_W  nibble page; digit d shows nibble index page_sel*NUM_DIGITS+d.
REQ-010 hold  input  1  freeze the displayed snapshot.
REQ-011 blank_lz  input  1  enable leading-zero blanking.
REQ-012 dp_mask  input  NUM_DIGITS  decimal point request per digit.
REQ-013 an  output  NUM_DIGITS  digit enables, active-low, at most one bit low.
REQ-014 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-015 dp  output  1  decimal point, active-low.
REQ-016 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-017 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be high for one cycle when the count equals REFRESH_DIV-1.
REQ-018 Digit index idx SHALL advance on tick, 0..NUM_DIGITS-1, and wrap to 0.
REQ-019 Frame wrap is tick with idx==NUM_DIGITS-1; at that edge frame_done SHALL pulse for exactly one cycle.
REQ-020 At frame wrap with hold=0, shadow data SHALL load data_in and shadow page SHALL load page_sel; with hold=1 both SHALL keep their values.
REQ-021 A change to data_in or page_sel mid-frame SHALL NOT be visible before the next frame wrap, so no torn frames.
REQ-022 Nibble index >= DATA_W/4 (page out of range) SHALL blank that digit: seg=7'h7F, dp=1, and an for that digit high.
REQ-023 Hex decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 With blank_lz=1, digit d>0 SHALL be blanked (an bit high, seg=7'h7F, dp=1) when nibbles d..NUM_DIGITS-1 of the current page are all zero; digit 0 is never lz-blanked.
REQ-025 an, seg, and dp SHALL be registered and SHALL update in the cycle after tick, reflecting the new idx and the current shadow.
REQ-026 an[idx] SHALL be low and all other an bits high; seg and dp SHALL change only when an changes (glitch-free).
REQ-027 dp SHALL equal ~dp_mask[idx], sampled live, unless the digit is blanked.
REQ-028 rst asserted mid-frame SHALL abandon the frame immediately with no frame_done.

Reset
REQ-029 While rst=1: prescaler=0, idx=0, shadow data=0, shadow page=0, an=all ones, seg=7'h7F, dp=1, frame_done=0.
REQ-030 After rst deasserts, the first tick SHALL occur REFRESH_DIV cycles later, and digit 0 SHALL display from shadow data=0 until the first frame wrap.

Structure
REQ-031 The shared package SHALL hold the hex-to-segment constant table and the SEG_BLANK constant (7'h7F).
REQ-032 A sub-module seg_hex_decode SHALL provide a combinational 4-bit to 7-bit decode; the prescaler, idx, shadow, and blanking logic SHALL be in seg_scan_driver.

Verification
REQ-033 Bench parameters SHALL be NUM_DIGITS=4 and REFRESH_DIV=4.
REQ-034 Reset: rst pulsed mid-frame -> an=4'hF, seg=7'h7F, dp=1, frame_done=0 while rst=1; idx restarts at 0.
REQ-035 data_in=32'h1234ABCD, page_sel=0, one frame loaded -> (an,seg) sequence (1110,0100001), (1101,1000110), (1011,0000011), (0111,0001000).
REQ-036 page_sel=1, same data -> digits 0..3 show 4,3,2,1; page_sel=2 -> all four digits blanked, an stays 4'hF.
REQ-037 blank_lz=1, data_in=32'h00000005 -> only an=1110 with seg=0010010 per frame; data_in=0 -> digit 0 shows 1000000.
REQ-038 Mid-frame data_in change -> old value is shown until frame_done, then the new value; with hold=1 across three frames the display is unchanged.
